token_tx: RTL and testbench
===========================

TOKEN_TX -- requirements
Module: token_tx

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; it SHALL have no parameters.
REQ-002 i_token_tx_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 i_token_tx_rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_token_tx_pid  in  4  token PID: OUT 0001, IN 1001, SETUP 1101, SOF 0101.
REQ-005 i_token_tx_addr  in  7  device address; ignored for SOF.
REQ-006 i_token_tx_endp  in  4  endpoint number; ignored for SOF.
REQ-007 i_token_tx_frame  in  11  frame number; used only for SOF.
REQ-008 i_token_tx_valid  in  1  token request valid.
REQ-009 o_token_tx_ready  out  1  request accepted when valid and ready are both high.
REQ-010 i_token_tx_gap  in  6  number of idle cycles inserted after each packet.
REQ-011 o_token_tx_lp_sop / o_token_tx_lp_eop / o_token_tx_lp_valid  out  1 each  byte stream toward the link-phy.
REQ-012 o_token_tx_lp_data  out  8  byte stream data.
REQ-013 i_token_tx_lp_ready  in  1  link-phy accepts a byte when it and lp_valid are both high.
REQ-014 o_token_tx_pid_err  out  1  one-cycle pulse when a request is dropped.

Function
REQ-015 The block SHALL use the states IDLE, BYTE0, BYTE1, BYTE2 and GAP; o_token_tx_ready SHALL be high only in IDLE.
REQ-016 On acceptance of a request with a legal PID, the block SHALL register the PID and the 11-bit field and compute the CRC5.
  - The 11-bit field is {endp, addr} for tokens and frame[10:0] for SOF.
REQ-017 After a legal acceptance the block SHALL move to BYTE0, with lp_valid high on the next cycle.
REQ-018 If the PID is illegal, the block SHALL pulse pid_err in the cycle after acceptance, remain in IDLE and emit nothing.
REQ-019 Byte content SHALL be as follows:
  - BYTE0 = {~pid, pid}, with sop=1.
  - BYTE1 = field[7:0].
  - BYTE2 = {crc_out[4:0], field[10:8]}, with eop=1.
REQ-020 CRC5 SHALL be computed serially with polynomial x^5+x^2+1 and initial value 11111.
  - Input is the field bits, LSB first; per bit: fb = d ^ c[4], shift left, XOR 00101 if fb.
  - The final register is inverted.
  - The inverted c[4] is placed in BYTE2 bit3 and the inverted c[0] in bit7.
REQ-021 A byte SHALL advance only on the cycle where lp_valid and lp_ready are both high; until then data, sop, eop and valid SHALL hold stable.
REQ-022 After the BYTE2 transfer the block SHALL enter GAP and count i_token_tx_gap cycles (sampled at BYTE2 transfer) before returning to IDLE.
  - A gap of 0 SHALL return directly to IDLE.
REQ-023 The minimum request-to-request spacing SHALL be 4 + gap cycles when lp_ready is held high.
REQ-024 Requests presented while ready is low SHALL be ignored; the requester holds them.
REQ-025 sop and eop SHALL be low whenever lp_valid is low.

Reset
REQ-026 While rst_n is low, the block SHALL hold the state at IDLE and force ready=1, all lp outputs 0, data 8'h00 and pid_err 0.
REQ-027 A reset asserted mid-packet SHALL abandon the packet at once; no partial byte SHALL be emitted after release.

Configuration
REQ-028 With TOKEN_TX_SOF_EN defined, PID 0101 SHALL be legal and SHALL use the frame field.
REQ-029 Without TOKEN_TX_SOF_EN, PID 0101 SHALL be illegal (pid_err, dropped), and the frame port SHALL remain present but unused.

Verification
REQ-030 Reset, then SETUP with addr 0, endp 0 and lp_ready held high SHALL produce bytes 0x2D(sop), 0x00, 0x10(eop) on 3 consecutive cycles.
REQ-031 IN with addr 8, endp 0 SHALL produce 0x69, 0x08, 0x60; toggling lp_ready low for 20 cycles between bytes SHALL leave the bytes stable and unchanged.
REQ-032 PID 0011 (DATA0) requested SHALL produce one pid_err pulse, no lp_valid and ready staying high.
REQ-033 gap=10 with back-to-back requests SHALL leave exactly 10 cycles between eop transfer and ready high.
REQ-034 rst_n low during BYTE1 SHALL drop lp_valid within the reset cycle; after release the next request SHALL start with a fresh sop.
REQ-035 SOF with frame 0 SHALL produce 0xA5, 0x00, 0x10 when TOKEN_TX_SOF_EN is defined, and pid_err when it is not.

Source files
------------

// File: rtl/token_tx.sv
// -----------------------------------------------------------------------------
// token_tx -- USB token packet transmitter
//
// Accepts a token request (PID + address/endpoint, or frame number for SOF),
// computes the CRC5 over the 11-bit token field and emits a three-byte packet
// toward the link-phy on a valid/ready byte stream. After each packet a
// programmable number of idle cycles is inserted before the next request is
// accepted. Requests carrying a PID that is not a legal token are dropped
// and flagged with a one-cycle pid_err pulse.
//
// Build option:
//   TOKEN_TX_SOF_EN  when defined, PID 0101 (SOF) is legal and its 11-bit field
//                    comes from i_token_tx_frame. When undefined, SOF is
//                    rejected like any other illegal PID and the frame port
//                    is present but unused.
//
// Ports:
//   i_token_tx_clk       clock, all state changes on its rising edge
//   i_token_tx_rst_n     asynchronous active-low reset
//   i_token_tx_pid       token PID (OUT 0001, IN 1001, SETUP 1101, SOF 0101)
//   i_token_tx_addr      device address (ignored for SOF)
//   i_token_tx_endp      endpoint number (ignored for SOF)
//   i_token_tx_frame     frame number (SOF only)
//   i_token_tx_valid     request valid
//   o_token_tx_ready     request accepted when valid && ready (high in IDLE only)
//   i_token_tx_gap       idle cycles inserted after each packet
//   o_token_tx_lp_sop    first byte of packet
//   o_token_tx_lp_eop    last byte of packet
//   o_token_tx_lp_valid  byte stream valid
//   o_token_tx_lp_data   byte stream data
//   i_token_tx_lp_ready  link-phy accepts a byte when valid && ready
//   o_token_tx_pid_err   one-cycle pulse when a request is dropped
// -----------------------------------------------------------------------------
module token_tx (
    input  logic        i_token_tx_clk,
    input  logic        i_token_tx_rst_n,
    input  logic [3:0]  i_token_tx_pid,
    input  logic [6:0]  i_token_tx_addr,
    input  logic [3:0]  i_token_tx_endp,
    input  logic [10:0] i_token_tx_frame,
    input  logic        i_token_tx_valid,
    output logic        o_token_tx_ready,
    input  logic [5:0]  i_token_tx_gap,
    output logic        o_token_tx_lp_sop,
    output logic        o_token_tx_lp_eop,
    output logic        o_token_tx_lp_valid,
    output logic [7:0]  o_token_tx_lp_data,
    input  logic        i_token_tx_lp_ready,
    output logic        o_token_tx_pid_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BYTE0 = 3'd1,
        ST_BYTE1 = 3'd2,
        ST_BYTE2 = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_SOF   = 4'b0101;

    state_t      state_reg, state_next;
    logic [3:0]  pid_reg, pid_next;
    logic [10:0] field_reg, field_next;
    logic [4:0]  crc_reg, crc_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic        pid_err_reg, pid_err_next;

    logic        pid_legal;
    logic [10:0] field_in;
    logic [4:0]  crc_calc;
    logic [4:0]  crc_out;
    logic        crc_fb;

    // ------------------------------------------------------------------
    // PID legality and selection of the 11-bit token field
    // ------------------------------------------------------------------
`ifdef TOKEN_TX_SOF_EN
    always_comb begin
        pid_legal = (i_token_tx_pid == PID_OUT)   ||
                    (i_token_tx_pid == PID_IN)    ||
                    (i_token_tx_pid == PID_SETUP) ||
                    (i_token_tx_pid == PID_SOF);
        field_in  = (i_token_tx_pid == PID_SOF) ? i_token_tx_frame
                                                : {i_token_tx_endp, i_token_tx_addr};
    end
`else
    // Frame number is only meaningful for SOF, which this build rejects.
    logic unused_frame;
    assign unused_frame = ^i_token_tx_frame;

    always_comb begin
        pid_legal = (i_token_tx_pid == PID_OUT) ||
                    (i_token_tx_pid == PID_IN)  ||
                    (i_token_tx_pid == PID_SETUP);
        field_in  = {i_token_tx_endp, i_token_tx_addr};
    end
`endif

    // ------------------------------------------------------------------
    // Serial CRC5 (x^5 + x^2 + 1, seed 11111) unrolled over the 11 field
    // bits, LSB first. Evaluated on the incoming field so the result can be
    // latched in the same cycle the request is accepted.
    // ------------------------------------------------------------------
    always_comb begin
        crc_calc = 5'b11111;
        crc_fb   = 1'b0;
        for (int i = 0; i < 11; i++) begin
            crc_fb   = field_in[i] ^ crc_calc[4];
            crc_calc = {crc_calc[3:0], 1'b0} ^ (crc_fb ? 5'b00101 : 5'b00000);
        end
    end

    // Transmitted CRC is the inverted register, bit-reversed so that c[4]
    // lands in byte bit 3 and c[0] in byte bit 7.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_crc_rev
            assign crc_out[gi] = ~crc_calc[4 - gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_token_tx_clk or negedge i_token_tx_rst_n) begin
        if (!i_token_tx_rst_n) begin
            state_reg   <= ST_IDLE;
            pid_reg     <= 4'h0;
            field_reg   <= 11'h000;
            crc_reg     <= 5'h00;
            cnt_reg     <= 6'h00;
            pid_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pid_reg     <= pid_next;
            field_reg   <= field_next;
            crc_reg     <= crc_next;
            cnt_reg     <= cnt_next;
            pid_err_reg <= pid_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and outputs. Byte outputs are decoded from the current
    // state and registered fields, so they stay stable while stalled and
    // vanish immediately when reset forces the state back to IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_next          = state_reg;
        pid_next            = pid_reg;
        field_next          = field_reg;
        crc_next            = crc_reg;
        cnt_next            = cnt_reg;
        pid_err_next        = 1'b0;
        o_token_tx_ready    = 1'b0;
        o_token_tx_lp_valid = 1'b0;
        o_token_tx_lp_sop   = 1'b0;
        o_token_tx_lp_eop   = 1'b0;
        o_token_tx_lp_data  = 8'h00;

        case (state_reg)
            ST_IDLE: begin
                o_token_tx_ready = 1'b1;
                if (i_token_tx_valid) begin
                    if (pid_legal) begin
                        pid_next   = i_token_tx_pid;
                        field_next = field_in;
                        crc_next   = crc_out;
                        state_next = ST_BYTE0;
                    end else begin
                        pid_err_next = 1'b1;
                    end
                end
            end

            ST_BYTE0: begin
                o_token_tx_lp_valid = 1'b1;
                o_token_tx_lp_sop   = 1'b1;
                o_token_tx_lp_data  = {~pid_reg, pid_reg};
                if (i_token_tx_lp_ready) begin
                    state_next = ST_BYTE1;
                end
            end

            ST_BYTE1: begin
                o_token_tx_lp_valid = 1'b1;
                o_token_tx_lp_data  = field_reg[7:0];
                if (i_token_tx_lp_ready) begin
                    state_next = ST_BYTE2;
                end
            end

            ST_BYTE2: begin
                o_token_tx_lp_valid = 1'b1;
                o_token_tx_lp_eop   = 1'b1;
                o_token_tx_lp_data  = {crc_reg, field_reg[10:8]};
                if (i_token_tx_lp_ready) begin
                    // Gap length is captured at the final byte transfer.
                    if (i_token_tx_gap == 6'd0) begin
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next   = i_token_tx_gap;
                        state_next = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                // cnt_reg holds the number of GAP cycles still to spend,
                // including the current one.
                if (cnt_reg <= 6'd1) begin
                    cnt_next   = 6'd0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 6'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_token_tx_pid_err = pid_err_reg;

endmodule

// File: tb/tb_token_tx.sv
// -----------------------------------------------------------------------------
// tb_token_tx -- directed self-checking bench for token_tx
//
// Directed vectors with hand-computed packet bytes. Outputs are sampled on the
// falling clock edge; inputs are driven there too. Build with TOKEN_TX_SOF_EN
// defined to exercise the SOF path, otherwise SOF is expected to be rejected.
// -----------------------------------------------------------------------------
module tb_token_tx;

    logic        clk;
    logic        rst_n;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame;
    logic        valid;
    logic        ready;
    logic [5:0]  gap;
    logic        lp_sop;
    logic        lp_eop;
    logic        lp_valid;
    logic [7:0]  lp_data;
    logic        lp_ready;
    logic        pid_err;

    int checks   = 0;
    int failures = 0;

    token_tx dut (
        .i_token_tx_clk      (clk),
        .i_token_tx_rst_n    (rst_n),
        .i_token_tx_pid      (pid),
        .i_token_tx_addr     (addr),
        .i_token_tx_endp     (endp),
        .i_token_tx_frame    (frame),
        .i_token_tx_valid    (valid),
        .o_token_tx_ready    (ready),
        .i_token_tx_gap      (gap),
        .o_token_tx_lp_sop   (lp_sop),
        .o_token_tx_lp_eop   (lp_eop),
        .o_token_tx_lp_valid (lp_valid),
        .o_token_tx_lp_data  (lp_data),
        .i_token_tx_lp_ready (lp_ready),
        .o_token_tx_pid_err  (pid_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Present a request for exactly one rising edge; returns on the next
    // falling edge with the request withdrawn.
    task automatic send(input logic [3:0] p, input logic [6:0] a,
                        input logic [3:0] e, input logic [10:0] f);
        pid   = p;
        addr  = a;
        endp  = e;
        frame = f;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Check the byte currently on the stream, then let one edge pass.
    task automatic expect_byte(input string tag, input logic [7:0] d,
                               input logic s, input logic eo);
        check({tag, "_valid"}, {31'd0, lp_valid}, 32'd1);
        check({tag, "_data"},  {24'd0, lp_data},  {24'd0, d});
        check({tag, "_sop"},   {31'd0, lp_sop},   {31'd0, s});
        check({tag, "_eop"},   {31'd0, lp_eop},   {31'd0, eo});
        @(negedge clk);
    endtask

    // Stall the link for 20 cycles, verify the byte never moved, then
    // release and check the byte is transferred.
    task automatic stall_byte(input string tag, input logic [7:0] d,
                              input logic s, input logic eo);
        int bad;
        bad = 0;
        lp_ready = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (lp_valid !== 1'b1 || lp_data !== d || lp_sop !== s || lp_eop !== eo)
                bad++;
        end
        check({tag, "_stall_unstable_cycles"}, bad, 0);
        lp_ready = 1'b1;
        expect_byte(tag, d, s, eo);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1)
            check({tag, "_idle_timeout"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        pid      = 4'h0;
        addr     = 7'h00;
        endp     = 4'h0;
        frame    = 11'h000;
        valid    = 1'b0;
        gap      = 6'd0;
        lp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready",    {31'd0, ready},    32'd1);
        check("rst_lp_valid", {31'd0, lp_valid}, 32'd0);
        check("rst_sop",      {31'd0, lp_sop},   32'd0);
        check("rst_eop",      {31'd0, lp_eop},   32'd0);
        check("rst_data",     {24'd0, lp_data},  32'd0);
        check("rst_pid_err",  {31'd0, pid_err},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SETUP addr 0 endp 0, three consecutive bytes
        send(4'b1101, 7'd0, 4'd0, 11'd0);
        expect_byte("setup_b0", 8'h2D, 1'b1, 1'b0);
        expect_byte("setup_b1", 8'h00, 1'b0, 1'b0);
        expect_byte("setup_b2", 8'h10, 1'b0, 1'b1);
        check("setup_done_ready", {31'd0, ready},    32'd1);
        check("setup_done_valid", {31'd0, lp_valid}, 32'd0);

        // IN addr 8 endp 0 with 20-cycle stalls on every byte
        send(4'b1001, 7'd8, 4'd0, 11'd0);
        stall_byte("in_b0", 8'h69, 1'b1, 1'b0);
        stall_byte("in_b1", 8'h08, 1'b0, 1'b0);
        stall_byte("in_b2", 8'h60, 1'b0, 1'b1);
        check("in_done_ready", {31'd0, ready}, 32'd1);

        // Illegal PID (DATA0) dropped with a single pid_err pulse
        send(4'b0011, 7'd5, 4'd2, 11'd0);
        check("data0_pid_err", {31'd0, pid_err},  32'd1);
        check("data0_valid",   {31'd0, lp_valid}, 32'd0);
        check("data0_ready",   {31'd0, ready},    32'd1);
        @(negedge clk);
        check("data0_pid_err_clear", {31'd0, pid_err},  32'd0);
        check("data0_valid_after",   {31'd0, lp_valid}, 32'd0);

        // Back-to-back with gap 0: sop to sop spacing of 4 cycles
        pid = 4'b0001; addr = 7'd0; endp = 4'd0;
        valid = 1'b1;
        @(negedge clk);
        check("b2b_first_sop", {31'd0, lp_sop}, 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (lp_sop !== 1'b1 && n < 20);
        valid = 1'b0;
        check("b2b_spacing", n, 4);
        @(negedge clk);
        wait_idle("b2b");

        // gap 10: exactly 10 cycles between eop transfer and ready
        gap   = 6'd10;
        pid   = 4'b0001; addr = 7'd0; endp = 4'd0;
        valid = 1'b1;
        @(negedge clk);
        expect_byte("out_b0", 8'hE1, 1'b1, 1'b0);
        expect_byte("out_b1", 8'h00, 1'b0, 1'b0);
        check("out_b2_data", {24'd0, lp_data}, 32'h10);
        check("out_b2_eop",  {31'd0, lp_eop},  32'd1);
        n = 0;
        forever begin
            @(negedge clk);
            if (ready === 1'b1 || n >= 100) break;
            n++;
        end
        check("gap10_cycles", n, 10);
        @(negedge clk);
        valid = 1'b0;
        check("gap10_next_sop", {31'd0, lp_sop}, 32'd1);
        repeat (3) @(negedge clk);
        wait_idle("gap10");
        gap = 6'd0;

        // Reset while BYTE1 is on the stream
        send(4'b1101, 7'd0, 4'd0, 11'd0);
        @(negedge clk);
        check("mid_b1_data", {24'd0, lp_data}, 32'h00);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, lp_valid}, 32'd0);
        check("mid_rst_sop",   {31'd0, lp_sop},   32'd0);
        check("mid_rst_eop",   {31'd0, lp_eop},   32'd0);
        check("mid_rst_ready", {31'd0, ready},    32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_post_valid", {31'd0, lp_valid}, 32'd0);
        send(4'b1001, 7'd8, 4'd0, 11'd0);
        expect_byte("post_b0", 8'h69, 1'b1, 1'b0);
        expect_byte("post_b1", 8'h08, 1'b0, 1'b0);
        expect_byte("post_b2", 8'h60, 1'b0, 1'b1);

        // SOF frame 0
        send(4'b0101, 7'd0, 4'd0, 11'd0);
`ifdef TOKEN_TX_SOF_EN
        check("sof_pid_err", {31'd0, pid_err}, 32'd0);
        expect_byte("sof_b0", 8'hA5, 1'b1, 1'b0);
        expect_byte("sof_b1", 8'h00, 1'b0, 1'b0);
        expect_byte("sof_b2", 8'h10, 1'b0, 1'b1);
`else
        check("sof_pid_err", {31'd0, pid_err},  32'd1);
        check("sof_valid",   {31'd0, lp_valid}, 32'd0);
        check("sof_ready",   {31'd0, ready},    32'd1);
`endif
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
